// File: rtl/tick_scheduler.sv
// Round-robin tick scheduler: grants one requester at a time and issues
// cnt periodic tick pulses spaced div clock cycles apart, then a done pulse.
module tick_scheduler #(
  parameter int N_REQ = 4,
  parameter int DW    = 16,
  parameter int CW    = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ*DW-1:0] div_i,
  input  logic [N_REQ*CW-1:0] cnt_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic               tick_o,
  output logic [N_REQ-1:0]   done_o,
  output logic               busy_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [PW-1:0]     ptr_reg, ptr_next;
  logic [PW-1:0]     owner_reg, owner_next;
  logic [DW-1:0]     div_reg, div_next;
  logic [DW-1:0]     phase_reg, phase_next;
  logic [CW-1:0]     left_reg, left_next;
  logic [N_REQ-1:0]  gnt_reg, gnt_next;
  logic [N_REQ-1:0]  done_reg, done_next;
  logic              tick_reg, tick_next;
  logic              busy_reg, busy_next;

  logic [DW-1:0]     div_sl [N_REQ];
  logic [CW-1:0]     cnt_sl [N_REQ];
  logic              win_valid;
  logic [PW-1:0]     win_idx;
  logic [PW:0]       cand;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign div_sl[gi] = div_i[gi*DW +: DW];
    assign cnt_sl[gi] = cnt_i[gi*CW +: CW];
  end

  // Scan offsets from the top down so the smallest offset from ptr wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      cand = {1'b0, ptr_reg} + (PW+1)'(off);
      if (cand >= (PW+1)'(N_REQ)) begin
        cand = cand - (PW+1)'(N_REQ);
      end
      if (req_i[cand[PW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    div_next   = div_reg;
    phase_next = phase_reg;
    left_next  = left_reg;
    gnt_next   = gnt_reg;
    busy_next  = busy_reg;
    tick_next  = 1'b0;
    done_next  = '0;

    unique case (state_reg)
      S_IDLE: begin
        if (win_valid) begin
          state_next = S_RUN;
          owner_next = win_idx;
          gnt_next   = N_REQ'(1) << win_idx;
          div_next   = (div_sl[win_idx] < DW'(2)) ? DW'(2) : div_sl[win_idx];
          left_next  = cnt_sl[win_idx];
          phase_next = '0;
          ptr_next   = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + PW'(1);
          busy_next  = 1'b1;
        end
      end

      S_RUN: begin
        // Abort wins over everything, including a coinciding final tick.
        if (!req_i[owner_reg]) begin
          state_next = S_IDLE;
          gnt_next   = '0;
          busy_next  = 1'b0;
          phase_next = '0;
          left_next  = '0;
        end else if (left_reg == '0) begin
          state_next           = S_DONE;
          gnt_next             = '0;
          done_next[owner_reg] = 1'b1;
          phase_next           = '0;
        end else if (phase_reg == div_reg - DW'(1)) begin
          tick_next  = 1'b1;
          phase_next = '0;
          left_next  = left_reg - CW'(1);
        end else begin
          phase_next = phase_reg + DW'(1);
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
        busy_next  = 1'b0;
      end

      default: begin
        state_next = S_IDLE;
        gnt_next   = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= S_IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      div_reg   <= '0;
      phase_reg <= '0;
      left_reg  <= '0;
      gnt_reg   <= '0;
      done_reg  <= '0;
      tick_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      div_reg   <= div_next;
      phase_reg <= phase_next;
      left_reg  <= left_next;
      gnt_reg   <= gnt_next;
      done_reg  <= done_next;
      tick_reg  <= tick_next;
      busy_reg  <= busy_next;
    end
  end

  assign gnt_o  = gnt_reg;
  assign done_o = done_reg;
  assign tick_o = tick_reg;
  assign busy_o = busy_reg;

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: a service-level model predicts grant,
// tick, release and done events by cycle; a monitor checks what the DUT shows.
module tb_tick_scheduler;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int CW = 8;

  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_TICK = 2;
  localparam int K_DONE = 3;

  logic              clk;
  logic              rst_ni;
  logic [N-1:0]      req_i;
  logic [N*DW-1:0]   div_i;
  logic [N*CW-1:0]   cnt_i;
  logic [N-1:0]      gnt_o;
  logic              tick_o;
  logic [N-1:0]      done_o;
  logic              busy_o;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  m_ptr = 0;

  tick_scheduler #(.N_REQ(N), .DW(DW), .CW(CW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .req_i  (req_i),
    .div_i  (div_i),
    .cnt_i  (cnt_i),
    .gnt_o  (gnt_o),
    .tick_o (tick_o),
    .done_o (done_o),
    .busy_o (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  function automatic string kname(input int k);
    case (k)
      K_RISE:  return "grant";
      K_FALL:  return "release";
      K_TICK:  return "tick";
      default: return "done";
    endcase
  endfunction

  task automatic push_ev(input int c, input int k, input int v);
    ev_t e;
    e.cyc = c; e.kind = k; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic obs_event(input int k, input int v);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: got val=%0h at cycle %0d, required no event", kname(k), v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.val != v)
        begin
          bad++;
          $display("FAIL event_%s: got %s val=%0h cycle=%0d, required %s val=%0h cycle=%0d",
                   kname(e.kind), kname(k), v, cyc, kname(e.kind), e.val, e.cyc);
        end
      else
        $display("ok %s val=%0h cycle=%0d", kname(k), v, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    logic [N-1:0] prev_gnt;
    ev_t e;
    prev_gnt = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        prev_gnt = '0;
      end else begin
        total++;
        if (!$onehot0(gnt_o)) begin
          bad++;
          $display("FAIL gnt_onehot: got gnt=%b, required at most one bit", gnt_o);
        end
        total++;
        if (busy_o !== ((gnt_o != '0) || (done_o != '0))) begin
          bad++;
          $display("FAIL busy: got %b with gnt=%b done=%b, required %b",
                   busy_o, gnt_o, done_o, (gnt_o != '0) || (done_o != '0));
        end
        if (prev_gnt != '0 && gnt_o != '0) begin
          total++;
          if (gnt_o != prev_gnt) begin
            bad++;
            $display("FAIL gnt_hold: got %b, required %b", gnt_o, prev_gnt);
          end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          total++;
          bad++;
          $display("FAIL missed_%s: got nothing, required val=%0h at cycle %0d",
                   kname(e.kind), e.val, e.cyc);
        end
        if (prev_gnt == '0 && gnt_o != '0) obs_event(K_RISE, int'(gnt_o));
        if (prev_gnt != '0 && gnt_o == '0) obs_event(K_FALL, int'(prev_gnt));
        if (tick_o) obs_event(K_TICK, 0);
        if (done_o != '0) obs_event(K_DONE, int'(done_o));
        prev_gnt = gnt_o;
      end
    end
  end

  task automatic set_all(input int d, input int c);
    for (int i = 0; i < N; i++) begin
      div_i[i*DW +: DW] = DW'(d);
      cnt_i[i*CW +: CW] = CW'(c);
    end
  endtask

  task automatic rand_cfg();
    for (int i = 0; i < N; i++) begin
      div_i[i*DW +: DW] = DW'($urandom_range(0, 6));
      cnt_i[i*CW +: CW] = CW'($urandom_range(0, 3));
    end
  endtask

  // Called at the falling edge of an idle cycle. abort_off: -1 none,
  // -2 random choice, otherwise cycles after the first granted cycle.
  task automatic service(input logic [N-1:0] mask, input int abort_off, input int gap);
    int w, d, c, g, a, run_len;
    logic [N*DW-1:0] div_save;
    logic [N*CW-1:0] cnt_save;
    w = -1;
    for (int off = 0; off < N; off++) begin
      if (w < 0 && mask[(m_ptr + off) % N]) w = (m_ptr + off) % N;
    end
    m_ptr = (w + 1) % N;
    d = int'(div_i[w*DW +: DW]);
    if (d < 2) d = 2;
    c = int'(cnt_i[w*CW +: CW]);
    run_len = c * d;
    a = abort_off;
    if (a == -2) a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, run_len)) : -1;
    if (a > run_len) a = run_len;

    req_i = mask;
    g = cyc + 1;
    push_ev(g, K_RISE, 1 << w);
    for (int k = 1; k <= c; k++) begin
      if (a < 0 || k * d <= a) push_ev(g + k * d, K_TICK, 0);
    end
    if (a < 0) begin
      push_ev(g + run_len + 1, K_FALL, 1 << w);
      push_ev(g + run_len + 1, K_DONE, 1 << w);
    end else begin
      push_ev(g + a + 1, K_FALL, 1 << w);
    end

    // Configuration changes after the grant must not affect the service.
    while (cyc < g) @(negedge clk);
    div_save = div_i;
    cnt_save = cnt_i;
    rand_cfg();
    if (a < 0) begin
      while (cyc < g + run_len + 1) @(negedge clk);
    end else begin
      while (cyc < g + a) @(negedge clk);
    end
    req_i = '0;
    @(negedge clk);
    div_i = div_save;
    cnt_i = cnt_save;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    total++;
    if (gnt_o !== '0 || tick_o !== 1'b0 || done_o !== '0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL %s: got gnt=%b tick=%b done=%b busy=%b, required all zero",
               name, gnt_o, tick_o, done_o, busy_o);
    end else begin
      $display("ok %s outputs zero", name);
    end
  endtask

  task automatic reset_mid_service();
    int g;
    set_all(4, 3);
    req_i = 4'b0001;
    m_ptr = 1;
    g = cyc + 1;
    push_ev(g, K_RISE, 1);
    push_ev(g + 4, K_TICK, 0);
    while (cyc < g + 5) @(negedge clk);
    @(posedge clk);
    #2;
    rst_ni = 1'b0;
    #1;
    check_zero("async_reset");
    exp_q.delete();
    m_ptr = 0;
    req_i = '0;
    @(negedge clk);
    check_zero("reset_hold");
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_ni = 1'b0;
    req_i  = '1;
    rand_cfg();
    repeat (3) @(negedge clk);
    check_zero("reset_pending_req");
    rst_ni = 1'b1;
    req_i  = '0;
    @(negedge clk);

    set_all(4, 3);
    service(4'b0001, -1, 1);

    set_all(2, 1);
    repeat (5) service(4'b1111, -1, 0);

    set_all(0, 2);
    service(4'b0100, -1, 1);
    set_all(5, 0);
    service(4'b0010, -1, 1);

    set_all(4, 3);
    service(4'b0001, 5, 0);
    set_all(2, 1);
    service(4'b1111, -1, 1);

    reset_mid_service();
    set_all(2, 1);
    service(4'b1111, -1, 1);

    repeat (80) begin
      rand_cfg();
      service(N'($urandom_range(1, (1 << N) - 1)), -2, int'($urandom_range(0, 2)));
    end

    repeat (5) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_events: got %0d pending, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (N_REQ >= 2).
REQ-002 The block SHALL have parameter DW, default 16, giving the divisor field width.
REQ-003 The block SHALL have parameter CW, default 8, giving the tick-count field width.
REQ-004 Port clk_i: input, 1 bit; the single clock, with all state updating on its rising edge.
REQ-005 Port rst_ni: input, 1 bit; asynchronous active-low reset.
REQ-006 Port req_i: input, N_REQ bits; per-requester service request, level, held until done or abandoned.
REQ-007 Port div_i: input, N_REQ*DW bits; requester i's tick period in clk_i cycles, at slice [i*DW +: DW].
REQ-008 Port cnt_i: input, N_REQ*CW bits; requester i's number of ticks to issue, at slice [i*CW +: CW].
REQ-009 Port gnt_o: output, N_REQ bits; one-hot grant, held for the whole service.
REQ-010 Port tick_o: output, 1 bit; one-cycle tick pulse for the current owner.
REQ-011 Port done_o: output, N_REQ bits; one-cycle completion pulse to the owner.
REQ-012 Port busy_o: output, 1 bit; high while the scheduler is in RUN or DONE.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-014 In IDLE with any req_i bit high, on the next edge the FSM SHALL:
- select a winner round-robin, searching from pointer ptr upward with wrap;
- set gnt_o to the winner's one-hot value;
- latch the winner's div_i and cnt_i slices;
- set ptr to (winner+1) mod N_REQ;
- enter RUN.
REQ-015 A latched divisor below 2 SHALL be replaced by 2; div_i and cnt_i changes during service SHALL be ignored.
REQ-016 In RUN, a DW-bit phase counter SHALL start at 0 on entry and increment every cycle.
REQ-017 When phase reaches div_q-1, the next edge SHALL:
- assert tick_o for one cycle;
- reset phase to 0;
- decrement ticks_left.
REQ-018 Tick timing: the k-th tick_o pulse SHALL occur exactly k*div_q cycles after the first cycle gnt_o is high.
REQ-019 After the tick that brings ticks_left to 0, the next edge SHALL enter DONE.
REQ-020 A latched count of 0 SHALL enter DONE one cycle after grant, with no tick_o issued.
REQ-021 In DONE, done_o[owner] SHALL be high for exactly one cycle; gnt_o SHALL be 0 in that cycle; the next edge SHALL return to IDLE.
REQ-022 Abort: if req_i[owner] is low in RUN, the next edge SHALL return to IDLE with:
- gnt_o = 0;
- no tick_o on that edge;
- no done_o;
- ptr already advanced.
REQ-023 If abort and the final tick coincide, the abort SHALL take precedence (no tick, no done).
REQ-024 Minimum spacing: at least one IDLE cycle SHALL separate consecutive grants, and gnt_o SHALL never have more than one bit set.
REQ-025 busy_o SHALL be high exactly in RUN and DONE.

Reset
REQ-026 While rst_ni is low, the block SHALL hold:
- FSM = IDLE;
- gnt_o = 0, tick_o = 0, done_o = 0, busy_o = 0;
- ptr = 0, phase = 0, ticks_left = 0.
REQ-027 Asserting rst_ni mid-RUN SHALL clear all state and outputs immediately, without waiting for a clock edge and with no done_o.
REQ-028 After rst_ni deasserts, the first grant SHALL follow the normal IDLE rule.

Verification
REQ-029 Reset: drive rst_ni low with requests pending -> all outputs read 0; after release, req_i=0001 -> gnt_o=0001 one cycle later.
REQ-030 Single service: req0, div=4, cnt=3 -> gnt_o=0001 first high at cycle G; tick_o at G+4, G+8, G+12; done_o=0001 and gnt_o=0 at G+13.
REQ-031 Round robin: req_i=1111 held, all div=2, cnt=1 -> grant order 0,1,2,3,0; each grant separated by one IDLE cycle; ptr wraps.
REQ-032 Boundaries:
- req2 with div=0, cnt=2 -> ticks at G+2 and G+4;
- req1 with cnt=0 -> done_o[1] at G+1 with no tick.
REQ-033 Abort: req0, div=4, cnt=3, req0 dropped at G+5 -> single tick at G+4; gnt_o=0 at G+6; no done_o; next grant goes to the requester after 0.
REQ-034 Reset during service: pull rst_ni low at G+6 of a div=4 service -> gnt_o, busy_o and tick_o drop immediately; no done_o; after release, ptr=0.
